// File: rtl/conv2_psum_drain.sv
// Conv-layer-2 psum drain: accumulates NPASS packed psum words per row, then
// requantises each lane (ReLU, shift, saturate) and streams lanes out one per handshake.

module conv2_psum_lane #(
    parameter int PSUM_W = 20,
    parameter int ACC_W  = 24,
    parameter int OUT_W  = 8,
    parameter int SHIFT  = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clr,
    input  logic              i_add,
    input  logic [PSUM_W-1:0] i_psum,
    output logic [OUT_W-1:0]  o_q
);
    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_shr;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_acc <= '0;
        else if (i_clr)
            r_acc <= '0;
        else if (i_add)
            r_acc <= r_acc + {{(ACC_W-PSUM_W){i_psum[PSUM_W-1]}}, i_psum};
    end

    // Negative sums clamp to zero; anything above OUT_W bits after the shift saturates.
    always_comb begin
        w_shr = r_acc >>> SHIFT;
        o_q   = w_shr[OUT_W-1:0];
        if (r_acc[ACC_W-1])
            o_q = '0;
        else if (|w_shr[ACC_W-1:OUT_W])
            o_q = '1;
    end
endmodule

module conv2_psum_drain #(
    parameter int LANES  = 12,
    parameter int PSUM_W = 20,
    parameter int ACC_W  = 24,
    parameter int OUT_W  = 8,
    parameter int NPASS  = 6,
    parameter int SHIFT  = 8,
    parameter int ROWS   = 12
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_clr,
    input  logic [LANES*PSUM_W-1:0] i_psum_in,
    input  logic                    i_psum_valid,
    output logic                    o_psum_ready,
    output logic [OUT_W-1:0]        o_out_data,
    output logic [3:0]              o_out_lane,
    output logic [3:0]              o_out_row,
    output logic                    o_out_last,
    output logic                    o_out_valid,
    input  logic                    i_out_ready
);
    localparam int PASS_W = (NPASS > 1) ? $clog2(NPASS) : 1;

    typedef enum logic {S_ACCUM, S_DRAIN} state_t;

    state_t                        r_state, w_next;
    logic [PASS_W-1:0]             r_pass;
    logic [3:0]                    r_lane;
    logic [3:0]                    r_row;
    logic [LANES-1:0][OUT_W-1:0]   w_q;
    logic                          w_accept, w_final, w_hs, w_last_lane, w_done;

    assign w_accept    = i_psum_valid & (r_state == S_ACCUM);
    assign w_final     = w_accept & (r_pass == PASS_W'(NPASS-1));
    assign w_last_lane = (r_lane == 4'(LANES-1));
    assign w_hs        = (r_state == S_DRAIN) & i_out_ready;
    assign w_done      = w_hs & w_last_lane;

    genvar k;
    generate
        for (k = 0; k < LANES; k++) begin : g_lane
            conv2_psum_lane #(
                .PSUM_W(PSUM_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(SHIFT)
            ) u_lane (
                .i_clk (i_clk),
                .i_rst (i_rst),
                .i_clr (i_clr | w_done),
                .i_add (w_accept),
                .i_psum(i_psum_in[LANES*PSUM_W-1-PSUM_W*k -: PSUM_W]),
                .o_q   (w_q[k])
            );
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_state <= S_ACCUM;
        else if (i_clr)
            r_state <= S_ACCUM;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        o_psum_ready = 1'b0;
        o_out_valid  = 1'b0;
        case (r_state)
            S_ACCUM: begin
                o_psum_ready = 1'b1;
                if (w_final) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                o_out_valid = 1'b1;
                if (w_done) w_next = S_ACCUM;
            end
            default: w_next = S_ACCUM;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pass <= '0;
            r_lane <= '0;
            r_row  <= '0;
        end else if (i_clr) begin
            r_pass <= '0;
            r_lane <= '0;
            r_row  <= '0;
        end else begin
            if (w_accept)
                r_pass <= w_final ? '0 : r_pass + 1'b1;
            if (w_hs)
                r_lane <= w_last_lane ? '0 : r_lane + 4'd1;
            if (w_done)
                r_row <= (r_row == 4'(ROWS-1)) ? '0 : r_row + 4'd1;
        end
    end

    // Lane and acc are frozen while stalled, so the muxed result stays stable.
    assign o_out_data = o_out_valid ? w_q[r_lane] : '0;
    assign o_out_lane = r_lane;
    assign o_out_last = o_out_valid & w_last_lane;
    assign o_out_row  = r_row;
endmodule

// File: tb/tb_conv2_psum_drain.sv
// Bench for conv2_psum_drain: two instances (NPASS=2/SHIFT=4/ROWS=3 and NPASS=1/SHIFT=0),
// table vectors, hand sequences for reset/clr/backpressure, and randomized rows vs a sum model.

module tb_conv2_psum_drain;
    localparam int L  = 12;
    localparam int PW = 20;
    localparam int NP [2] = '{2, 1};
    localparam int SH [2] = '{4, 0};
    localparam int RW [2] = '{3, 12};

    typedef int lanes_t [L];
    typedef struct {int a0; int a1; int ex;} vec_t;

    logic clk = 1'b0;
    logic rst;
    logic clr [2];
    logic pv [2];
    logic ordy [2];
    logic [L*PW-1:0] pin [2];
    logic pr [2];
    logic olast [2];
    logic ov [2];
    logic [7:0] od [2];
    logic [3:0] ol [2];
    logic [3:0] orow [2];

    int checks = 0;
    int errors = 0;
    longint macc [2][L];
    int mrow [2];

    always #5 clk = ~clk;

    conv2_psum_drain #(.NPASS(2), .SHIFT(4), .ROWS(3)) u_a (
        .i_clk(clk), .i_rst(rst), .i_clr(clr[0]), .i_psum_in(pin[0]), .i_psum_valid(pv[0]),
        .o_psum_ready(pr[0]), .o_out_data(od[0]), .o_out_lane(ol[0]), .o_out_row(orow[0]),
        .o_out_last(olast[0]), .o_out_valid(ov[0]), .i_out_ready(ordy[0]));

    conv2_psum_drain #(.NPASS(1), .SHIFT(0), .ROWS(12)) u_b (
        .i_clk(clk), .i_rst(rst), .i_clr(clr[1]), .i_psum_in(pin[1]), .i_psum_valid(pv[1]),
        .o_psum_ready(pr[1]), .o_out_data(od[1]), .o_out_lane(ol[1]), .o_out_row(orow[1]),
        .o_out_last(olast[1]), .o_out_valid(ov[1]), .i_out_ready(ordy[1]));

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic int q(input longint a, input int sh);
        longint t;
        if (a < 0) return 0;
        t = a / (longint'(1) << sh);
        return (t > 255) ? 255 : int'(t);
    endfunction

    task automatic mreset(input int d);
        for (int k = 0; k < L; k++) macc[d][k] = 0;
        mrow[d] = 0;
    endtask

    task automatic mexp(input int d, output lanes_t e);
        for (int k = 0; k < L; k++) e[k] = q(macc[d][k], SH[d]);
    endtask

    task automatic drive(input int d, input lanes_t v);
        for (int k = 0; k < L; k++) pin[d][L*PW-1-PW*k -: PW] = PW'(v[k]);
        for (int k = 0; k < L; k++) macc[d][k] += v[k];
    endtask

    task automatic send(input int d, input lanes_t v);
        @(negedge clk);
        pv[d] = 1'b1;
        drive(d, v);
        chk("psum_ready_accum", int'(pr[d]), 1);
        @(negedge clk);
        pv[d] = 1'b0;
    endtask

    // Called at the negedge after the final-pass accept; walks lanes until done or stop.
    task automatic drain(input int d, input lanes_t e, input bit bp, input bit junk,
                         input int stop, input int stall_at);
        int lane = 0;
        int stalls = 0;
        bit r;
        while (lane < L) begin
            if (lane == stop) return;
            r = !bp || stalls >= 3 || $urandom_range(0, 2) != 0;
            if (lane == stall_at && stalls < 3) r = 1'b0;
            ordy[d] = r;
            if (junk) begin
                pv[d] = 1'($urandom_range(0, 1));
                for (int k = 0; k < L; k++) pin[d][L*PW-1-PW*k -: PW] = PW'($urandom);
            end
            chk("out_valid", int'(ov[d]), 1);
            chk("out_lane", int'(ol[d]), lane);
            chk("out_data", int'(od[d]), e[lane]);
            chk("out_last", int'(olast[d]), int'(lane == L-1));
            chk("out_row", int'(orow[d]), mrow[d]);
            chk("psum_ready_drain", int'(pr[d]), 0);
            @(negedge clk);
            if (r) begin lane++; stalls = 0; end
            else stalls++;
        end
        if (junk) pv[d] = 1'b0;
        ordy[d] = 1'b1;
        for (int k = 0; k < L; k++) macc[d][k] = 0;
        mrow[d] = (mrow[d] + 1) % RW[d];
        chk("out_valid_end", int'(ov[d]), 0);
        chk("psum_ready_end", int'(pr[d]), 1);
        chk("out_data_idle", int'(od[d]), 0);
        chk("out_row_next", int'(orow[d]), mrow[d]);
    endtask

    task automatic uni(output lanes_t v, input int x);
        for (int k = 0; k < L; k++) v[k] = x;
    endtask

    initial begin
        vec_t   tbl [9];
        lanes_t v0, v1, e;

        tbl[0] = '{100, 60, 10};
        tbl[1] = '{-50, -50, 0};
        tbl[2] = '{524287, 524287, 255};
        tbl[3] = '{8, 8, 1};
        tbl[4] = '{0, 0, 0};
        tbl[5] = '{2040, 2040, 255};
        tbl[6] = '{2048, 2048, 255};
        tbl[7] = '{-1, 1, 0};
        tbl[8] = '{1000, -200, 50};

        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            clr[d] = 1'b0; pv[d] = 1'b0; ordy[d] = 1'b1; pin[d] = '0;
            mreset(d);
        end
        #12;
        for (int d = 0; d < 2; d++) begin
            chk("rst_out_valid", int'(ov[d]), 0);
            chk("rst_psum_ready", int'(pr[d]), 1);
            chk("rst_out_data", int'(od[d]), 0);
            chk("rst_out_lane", int'(ol[d]), 0);
            chk("rst_out_last", int'(olast[d]), 0);
            chk("rst_out_row", int'(orow[d]), 0);
        end
        @(negedge clk);
        rst = 1'b0;

        // table vectors: uniform lanes, two passes on the NPASS=2 instance
        for (int i = 0; i < 9; i++) begin
            uni(v0, tbl[i].a0);
            uni(v1, tbl[i].a1);
            uni(e, tbl[i].ex);
            send(0, v0);
            send(0, v1);
            drain(0, e, 1'b0, 1'b0, L, -1);
        end

        // mixed lanes: ReLU on lane 3, saturation on lane 5
        uni(v0, 0);
        v0[3] = -50;
        v0[5] = 524287;
        uni(e, 0);
        e[5] = 255;
        send(0, v0);
        send(0, v0);
        drain(0, e, 1'b0, 1'b0, L, -1);

        // backpressure at lane 4 with ignored psum_valid pulses, then a clean row
        uni(v0, 100); uni(v1, 60); uni(e, 10);
        send(0, v0); send(0, v1);
        drain(0, e, 1'b0, 1'b1, L, 4);
        send(0, v0); send(0, v1);
        drain(0, e, 1'b0, 1'b0, L, -1);

        // async reset mid-drain at lane 6
        send(0, v0); send(0, v1);
        drain(0, e, 1'b0, 1'b0, 6, -1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_out_valid", int'(ov[0]), 0);
        chk("rst_mid_psum_ready", int'(pr[0]), 1);
        chk("rst_mid_out_row", int'(orow[0]), 0);
        @(negedge clk);
        rst = 1'b0;
        mreset(0);
        mreset(1);
        send(0, v0); send(0, v1);
        drain(0, e, 1'b0, 1'b0, L, -1);

        // clr after one pass discards it
        uni(v1, 500);
        send(0, v1);
        @(negedge clk); clr[0] = 1'b1;
        @(negedge clk); clr[0] = 1'b0;
        mreset(0);
        chk("clr_psum_ready", int'(pr[0]), 1);
        chk("clr_out_row", int'(orow[0]), 0);
        uni(v1, 60);
        send(0, v0); send(0, v1);
        drain(0, e, 1'b0, 1'b0, L, -1);

        // NPASS=1: ramp lanes, psum_valid held across two drains
        for (int k = 0; k < L; k++) begin v0[k] = k * 20; e[k] = k * 20; end
        @(negedge clk);
        pv[1] = 1'b1;
        drive(1, v0);
        chk("b_psum_ready", int'(pr[1]), 1);
        @(negedge clk);
        drain(1, e, 1'b0, 1'b0, L, -1);
        drive(1, v0);
        @(negedge clk);
        drain(1, e, 1'b0, 1'b0, L, -1);
        pv[1] = 1'b0;

        // randomized rows against the sum model on both instances
        for (int it = 0; it < 16; it++) begin
            int d;
            d = (it % 4 == 3) ? 1 : 0;
            for (int p = 0; p < NP[d]; p++) begin
                for (int k = 0; k < L; k++)
                    v0[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1048575)) - 524288
                                                        : int'($urandom_range(0, 6000)) - 1000;
                send(d, v0);
            end
            mexp(d, e);
            drain(d, e, 1'b1, 1'b1, L, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
